i2c_master_gen2: RTL and testbench
==================================

I2C_MASTER_GEN2 -- requirements
Module: i2c_master_gen2

Interface
REQ-001 SHALL have parameter CW, default 64: command/status width, >=16, even.
REQ-002 SHALL have parameter HALF, default 512: CSTEP ticks per bus phase, >=2.
REQ-003 SHALL have parameter TMO, default 16384: CSTEP ticks allowed for SCL stretch before timeout.
REQ-004 SHALL have ports: CLOCK in 1 fpga clock; RESET in 1 reset.
REQ-005 SHALL use one clock, CLOCK; RESET is synchronous and active-low (asserted when 0, sampled on posedge CLOCK).
REQ-006 SHALL have ports: CSTEP in 1 timing tick enable; wrcmd in 1 load command; command in CW new command word.
REQ-007 SHALL have ports: comand out CW remaining command; status out CW busy/error/data; sclo out 1 SCL drive (1=release); sdao out 1 SDA drive (1=release); scli in 1 SCL sense; sdai in 1 SDA sense.

Function
REQ-008 SHALL treat comand[CW-1:CW-2] as the opcode: 00 stop/done; 01 repeated start; 10 read byte; 11 write byte, whose data is the following 8 bits, MSB first.
REQ-009 SHALL assign status[CW-1]=busy, [CW-2]=nack error, [CW-3]=stretch timeout, [CW-9:0]=read shift register; [CW-4:CW-8] read 0.
REQ-010 SHALL, on wrcmd (any state, overriding CSTEP): comand<=command, sclo=sdao=1, phase counter 0, status[CW-1:CW-3]<=100, state START; read data retained.
REQ-011 SHALL advance timing only on cycles with CSTEP=1 and wrcmd=0; one phase = HALF CSTEP ticks.
REQ-012 SHALL implement states IDLE, START, BEGIN, READ, WRITE, STOP, with phase sequencing as REQ-013..REQ-017.
REQ-013 START: phase, SDA low; phase, SCL low; then BEGIN.
REQ-014 BEGIN, one CSTEP: decode opcode, shift comand left 2 (zero-fill), counter 0; 00->SDA low, STOP; 01->release both, START; 10->release SDA, READ; 11->SDA=comand[CW-3], WRITE.
REQ-015 READ: 8 times {phase, SCL high; phase, sample sdai into status LSB (shift left), SCL low}; then ACK bit: SDA=0 if the next opcode (comand[CW-1:CW-2] after the BEGIN shift) is 10 or 11, else SDA released (NACK); phase SCL high; phase SCL low; phase SDA released; then BEGIN.
REQ-016 WRITE: per bit {phase SCL high; phase SCL low; phase drive next bit, shift comand left 1}; after bit 0: release SDA, phase SCL high, sample sdai; 0 -> phase SCL low, BEGIN; 1 -> status[CW-2]<=1, SCL low, SDA low, STOP.
REQ-017 STOP: phase SCL high; phase SDA high; phase; then IDLE, status[CW-1]<=0; error bits retained.
REQ-018 SHALL hold, in IDLE, sclo=sdao=1 and ignore CSTEP.
REQ-019 SHALL not change comand, status or outputs on CSTEP when not busy.
REQ-020 SHALL freeze read shift width at CW-8 bits; older bits fall off the MSB.

Reset
REQ-021 SHALL, with RESET=0 at posedge CLOCK: state IDLE, sclo=1, sdao=1, comand=0, status=0, counters 0; RESET overrides wrcmd.
REQ-022 SHALL, on reset mid-transfer, release the bus on the next cycle with no STOP generated.

Configuration
REQ-023 SHALL honour macro I2C_MASTER_STRETCH_EN: defined -> after each SCL release, the phase counter holds until scli=1; if TMO ticks pass with scli=0, status[CW-1:CW-3]<=011, sclo=sdao=1, state IDLE.
REQ-024 SHALL, without I2C_MASTER_STRETCH_EN, ignore scli, keep status[CW-3]=0, and time phases unconditionally.

Verification
REQ-025 Bench SHALL use HALF=4, TMO=40, CW=64, CSTEP every cycle.
REQ-026 Write 0xA0 ack, done: command=0xE800...0 (11,A0,00), sdai=0 at ACK -> SDA bits 1010_0000, STOP, status[63:61]=000.
REQ-027 Write NACK: command=0xC000..., sdai=1 at ACK -> status[62]=1, STOP generated, then busy=0.
REQ-028 Two reads: command=0xA000... (10,10,00), slave 0x5A then 0x3C -> first ACK SDA=0, second NACK SDA=1, status[15:0]=0x5A3C.
REQ-029 Stretch (macro on): hold scli=0 for 20 ticks -> phase extended, transfer ok; hold 50 ticks -> status[63:61]=011, sclo=sdao=1, IDLE.
REQ-030 RESET=0 mid-WRITE, and wrcmd mid-READ -> reset: all outputs per REQ-021 next cycle; wrcmd: restart START with busy=1, read data retained.

Source files
------------

// File: rtl/i2c_master_gen2.sv
// Command-driven I2C master: shifts 2-bit opcodes (stop/restart/read/write) out of a command word.
// Optional SCL clock-stretch support with timeout when I2C_MASTER_STRETCH_EN is defined.
module i2c_master_gen2 #(
  parameter int CW   = 64,
  parameter int HALF = 512,
  parameter int TMO  = 16384
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          CSTEP,
  input  logic          wrcmd,
  input  logic [CW-1:0] command,
  output logic [CW-1:0] comand,
  output logic [CW-1:0] status,
  output logic          sclo,
  output logic          sdao,
  input  logic          scli,
  input  logic          sdai
);

  localparam int CNT_W = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int RD_W  = CW - 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BEGIN, S_READ, S_WRITE, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        bit_q, bit_d;
  logic [CW-1:0]     comand_q, comand_d;
  logic              busy_q, busy_d;
  logic              nack_q, nack_d;
  logic              tout_q, tout_d;
  logic [RD_W-1:0]   rdata_q, rdata_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              tick, stall, adv, pdone;

`ifdef I2C_MASTER_STRETCH_EN
  localparam int TMO_W = $clog2(TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
  logic              wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  assign stall = wait_q & ~scli;
`else
  logic unused_stretch;
  assign unused_stretch = scli ^ (TMO == 0);
  assign stall = 1'b0;
`endif

  assign tick  = CSTEP & ~wrcmd;
  assign adv   = tick & ~stall & (state_q != S_IDLE);
  assign pdone = adv & (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    bit_d    = bit_q;
    comand_d = comand_q;
    busy_d   = busy_q;
    nack_d   = nack_q;
    tout_d   = tout_q;
    rdata_d  = rdata_q;
    scl_d    = scl_q;
    sda_d    = sda_q;
`ifdef I2C_MASTER_STRETCH_EN
    wait_d   = wait_q;
    tmo_d    = tmo_q;
`endif
    if (adv) cnt_d = pdone ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_START: if (pdone) begin
        if (step_q == 3'd0) begin
          sda_d  = 1'b0;
          step_d = 3'd1;
        end else begin
          scl_d   = 1'b0;
          step_d  = 3'd0;
          state_d = S_BEGIN;
        end
      end
      S_BEGIN: if (adv) begin
        cnt_d    = '0;
        step_d   = 3'd0;
        bit_d    = 3'd0;
        comand_d = comand_q << 2;
        case (comand_q[CW-1:CW-2])
          2'b00:   begin sda_d = 1'b0; state_d = S_STOP; end
          2'b01:   begin sda_d = 1'b1; scl_d = 1'b1; state_d = S_START; end
          2'b10:   begin sda_d = 1'b1; state_d = S_READ; end
          default: begin sda_d = comand_q[CW-3]; state_d = S_WRITE; end
        endcase
      end
      // Read: 8 sampled bits, then ACK only if another transfer opcode follows.
      S_READ: if (pdone) begin
        case (step_q)
          3'd0: begin scl_d = 1'b1; step_d = 3'd1; end
          3'd1: begin
            rdata_d = {rdata_q[RD_W-2:0], sdai};
            scl_d   = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d  = 3'd0;
              step_d = 3'd2;
              sda_d  = ~comand_q[CW-1];
            end else begin
              bit_d  = bit_q + 3'd1;
              step_d = 3'd0;
            end
          end
          3'd2: begin scl_d = 1'b1; step_d = 3'd3; end
          3'd3: begin scl_d = 1'b0; step_d = 3'd4; end
          default: begin sda_d = 1'b1; step_d = 3'd0; state_d = S_BEGIN; end
        endcase
      end
      S_WRITE: if (pdone) begin
        case (step_q)
          3'd0: begin scl_d = 1'b1; step_d = 3'd1; end
          3'd1: begin scl_d = 1'b0; step_d = 3'd2; end
          3'd2: begin
            comand_d = comand_q << 1;
            if (bit_q == 3'd7) begin
              sda_d  = 1'b1;
              bit_d  = 3'd0;
              step_d = 3'd3;
            end else begin
              sda_d  = comand_q[CW-2];
              bit_d  = bit_q + 3'd1;
              step_d = 3'd0;
            end
          end
          3'd3: begin scl_d = 1'b1; step_d = 3'd4; end
          default: begin
            scl_d  = 1'b0;
            step_d = 3'd0;
            if (sdai) begin
              nack_d  = 1'b1;
              sda_d   = 1'b0;
              state_d = S_STOP;
            end else begin
              state_d = S_BEGIN;
            end
          end
        endcase
      end
      S_STOP: if (pdone) begin
        case (step_q)
          3'd0: begin scl_d = 1'b1; step_d = 3'd1; end
          3'd1: begin sda_d = 1'b1; step_d = 3'd2; end
          default: begin step_d = 3'd0; busy_d = 1'b0; state_d = S_IDLE; end
        endcase
      end
      default: ;
    endcase

`ifdef I2C_MASTER_STRETCH_EN
    // A slave may hold SCL low after we release it; the phase counter waits for it.
    if (!scl_q && scl_d) begin
      wait_d = 1'b1;
      tmo_d  = '0;
    end else if (tick && wait_q && (state_q != S_IDLE)) begin
      if (scli) begin
        wait_d = 1'b0;
        tmo_d  = '0;
      end else if (tmo_q == TMO_LAST) begin
        busy_d  = 1'b0;
        nack_d  = 1'b1;
        tout_d  = 1'b1;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
        step_d  = 3'd0;
        bit_d   = 3'd0;
        wait_d  = 1'b0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    if (wrcmd) begin
      comand_d = command;
      scl_d    = 1'b1;
      sda_d    = 1'b1;
      cnt_d    = '0;
      step_d   = 3'd0;
      bit_d    = 3'd0;
      busy_d   = 1'b1;
      nack_d   = 1'b0;
      tout_d   = 1'b0;
      state_d  = S_START;
`ifdef I2C_MASTER_STRETCH_EN
      wait_d   = 1'b0;
      tmo_d    = '0;
`endif
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      step_q   <= 3'd0;
      bit_q    <= 3'd0;
      comand_q <= '0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
      tout_q   <= 1'b0;
      rdata_q  <= '0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
`ifdef I2C_MASTER_STRETCH_EN
      wait_q   <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      bit_q    <= bit_d;
      comand_q <= comand_d;
      busy_q   <= busy_d;
      nack_q   <= nack_d;
      tout_q   <= tout_d;
      rdata_q  <= rdata_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
`ifdef I2C_MASTER_STRETCH_EN
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign comand = comand_q;
  assign status = {busy_q, nack_q, tout_q, 5'b00000, rdata_q};
  assign sclo   = scl_q;
  assign sdao   = sda_q;

endmodule

// File: tb/tb_i2c_master_gen2.sv
// Directed bench for i2c_master_gen2 with a small wired-AND slave model on the bus.
module tb_i2c_master_gen2;
  localparam int CW = 64, HALF = 4, TMO = 40;
  localparam logic [1:0] B_NONE = 2'd0, B_WR = 2'd1, B_RD = 2'd2;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          CSTEP = 1'b1;
  logic          wrcmd = 1'b0;
  logic [CW-1:0] command = '0;
  logic [CW-1:0] comand, status;
  logic          sclo, sdao, scli, sdai;
  logic          stretch_n = 1'b1;
  logic          sl = 1'b1;

  assign scli = sclo & stretch_n;
  assign sdai = sdao & sl;

  i2c_master_gen2 #(.CW(CW), .HALF(HALF), .TMO(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP), .wrcmd(wrcmd), .command(command),
    .comand(comand), .status(status), .sclo(sclo), .sdao(sdao), .scli(scli), .sdai(sdai)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0, bad = 0;
  logic [1:0] btype [4];
  logic [7:0] rbyte [4];
  logic       ackv  [4];
  logic [8:0] frame [4];
  int starts = 0, stops = 0, falls = 0, ecnt = 0;
  logic scl_prev = 1'b1, sda_prev = 1'b1;

  // Bus monitor and slave: frames are 8 data bits + ACK, slave changes SDA after SCL falls.
  always @(negedge CLOCK) begin
    int pos, byt;
    if (scl_prev && sclo && sda_prev && !sdao) begin starts++; ecnt = 0; end
    if (scl_prev && sclo && !sda_prev && sdao) stops++;
    if (!scl_prev && sclo) begin
      byt = ecnt / 9; pos = ecnt % 9;
      if (byt < 4) frame[byt][8-pos] = sdao & sl;
      ecnt++;
    end
    if (scl_prev && !sclo) begin
      falls++;
      byt = ecnt / 9; pos = ecnt % 9;
      sl = 1'b1;
      if (byt < 4) begin
        if (btype[byt] == B_RD && pos < 8) sl = rbyte[byt][7-pos];
        else if (btype[byt] == B_WR && pos == 8) sl = ackv[byt];
      end
    end
    scl_prev = sclo;
    sda_prev = sdao;
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic issue(input logic [CW-1:0] c);
    command = c;
    wrcmd   = 1'b1;
    @(negedge CLOCK);
    wrcmd   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (status[CW-1] && cyc < limit) begin @(negedge CLOCK); cyc++; end
    chk("idle_reached", {63'b0, status[CW-1]}, 64'd0);
  endtask

  task automatic wait_falls(input int target, input int limit);
    int n = 0;
    while (falls < target && n < limit) begin @(negedge CLOCK); n++; end
    chk("falls_reached", {63'b0, falls >= target}, 64'd1);
  endtask

  task automatic set_slave(input logic [1:0] t0, input logic [7:0] d0, input logic a0,
                           input logic [1:0] t1, input logic [7:0] d1);
    btype[0] = t0; rbyte[0] = d0; ackv[0] = a0;
    btype[1] = t1; rbyte[1] = d1; ackv[1] = 1'b1;
    btype[2] = B_NONE; rbyte[2] = 8'h00; ackv[2] = 1'b1;
    btype[3] = B_NONE; rbyte[3] = 8'h00; ackv[3] = 1'b1;
  endtask

  initial begin
    int cyc, s0, st0, f0;
    set_slave(B_NONE, 8'h00, 1'b1, B_NONE, 8'h00);
    RESET = 1'b0;
    tick_n(3);
    chk("rst_sclo", {63'b0, sclo}, 64'd1);
    chk("rst_sdao", {63'b0, sdao}, 64'd1);
    chk("rst_comand", comand, 64'd0);
    chk("rst_status", status, 64'd0);
    RESET = 1'b1;
    tick_n(2);

    // Write 0xA0, slave ACKs, then stop.
    set_slave(B_WR, 8'h00, 1'b0, B_NONE, 8'h00);
    s0 = stops; st0 = starts;
    issue(64'hE800_0000_0000_0000);
    chk("wr_busy", {61'b0, status[CW-1:CW-3]}, 64'd4);
    chk("wr_comand_load", comand, 64'hE800_0000_0000_0000);
    wait_idle(400, cyc);
    chk("wr_frame", {55'b0, frame[0]}, 64'h140);
    chk("wr_start", 64'(starts - st0), 64'd1);
    chk("wr_stop", 64'(stops - s0), 64'd1);
    chk("wr_status", status, 64'd0);
    chk("wr_comand_end", comand, 64'd0);
    chk("wr_len", {63'b0, cyc >= 120 && cyc <= 132}, 64'd1);

    // Write 0x00, slave NACKs.
    set_slave(B_WR, 8'h00, 1'b1, B_NONE, 8'h00);
    s0 = stops;
    issue(64'hC000_0000_0000_0000);
    wait_idle(400, cyc);
    chk("nack_frame", {55'b0, frame[0]}, 64'h001);
    chk("nack_status", status, 64'h4000_0000_0000_0000);
    chk("nack_stop", 64'(stops - s0), 64'd1);

    // Two reads: ACK the first, NACK the last.
    set_slave(B_RD, 8'h5A, 1'b1, B_RD, 8'h3C);
    s0 = stops;
    issue(64'hA000_0000_0000_0000);
    wait_idle(600, cyc);
    chk("rd_frame0", {55'b0, frame[0]}, 64'h0B4);
    chk("rd_frame1", {55'b0, frame[1]}, 64'h079);
    chk("rd_status", status, 64'h0000_0000_0000_5A3C);
    chk("rd_stop", 64'(stops - s0), 64'd1);

    tick_n(20);
    chk("idle_status", status, 64'h0000_0000_0000_5A3C);
    chk("idle_bus", {62'b0, sclo, sdao}, 64'd3);

    set_slave(B_WR, 8'h00, 1'b0, B_NONE, 8'h00);
`ifdef I2C_MASTER_STRETCH_EN
    f0 = falls;
    issue(64'hE800_0000_0000_0000);
    wait_falls(f0 + 1, 100);
    stretch_n = 1'b0;
    cyc = 0;
    while (!sclo && cyc < 100) begin @(negedge CLOCK); cyc++; end
    tick_n(20);
    stretch_n = 1'b1;
    wait_idle(400, cyc);
    chk("str_frame", {55'b0, frame[0]}, 64'h140);
    chk("str_flags", {61'b0, status[CW-1:CW-3]}, 64'd0);
    chk("str_len", {63'b0, cyc >= 136 && cyc <= 160}, 64'd1);

    f0 = falls;
    issue(64'hE800_0000_0000_0000);
    wait_falls(f0 + 1, 100);
    stretch_n = 1'b0;
    cyc = 0;
    while (!sclo && cyc < 100) begin @(negedge CLOCK); cyc++; end
    tick_n(50);
    chk("tmo_flags", {61'b0, status[CW-1:CW-3]}, 64'd3);
    chk("tmo_bus", {62'b0, sclo, sdao}, 64'd3);
    stretch_n = 1'b1;
    tick_n(10);
    chk("tmo_stays_idle", {61'b0, status[CW-1:CW-3]}, 64'd3);
`else
    stretch_n = 1'b0;
    issue(64'hE800_0000_0000_0000);
    wait_idle(400, cyc);
    stretch_n = 1'b1;
    chk("nostr_frame", {55'b0, frame[0]}, 64'h140);
    chk("nostr_flags", {61'b0, status[CW-1:CW-3]}, 64'd0);
    chk("nostr_len", {63'b0, cyc >= 120 && cyc <= 132}, 64'd1);
`endif

    // New command arrives mid-read after three sampled bits (all ones).
    set_slave(B_RD, 8'hE0, 1'b1, B_NONE, 8'h00);
    f0 = falls;
    issue(64'h8000_0000_0000_0000);
    wait_falls(f0 + 4, 200);
    issue(64'h0);
    chk("wrc_status", status, 64'h8000_0000_0002_D1E7);
    chk("wrc_bus", {62'b0, sclo, sdao}, 64'd3);
    chk("wrc_comand", comand, 64'd0);
    wait_idle(400, cyc);
    chk("wrc_done", status, 64'h0000_0000_0002_D1E7);

    // Reset mid-write while wrcmd is also asserted.
    set_slave(B_WR, 8'h00, 1'b0, B_NONE, 8'h00);
    f0 = falls;
    issue(64'hE800_0000_0000_0000);
    wait_falls(f0 + 3, 200);
    s0 = stops;
    RESET   = 1'b0;
    wrcmd   = 1'b1;
    command = 64'hE800_0000_0000_0000;
    @(negedge CLOCK);
    RESET = 1'b1;
    wrcmd = 1'b0;
    chk("mrst_bus", {62'b0, sclo, sdao}, 64'd3);
    chk("mrst_comand", comand, 64'd0);
    chk("mrst_status", status, 64'd0);
    tick_n(30);
    chk("mrst_no_stop", 64'(stops - s0), 64'd0);
    chk("mrst_idle", status, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
